// File: rtl/frame_extremum_tracker_pkg.sv
// Shared definitions for the frame extremum tracker: comparator result codes,
// FSM state encodings and the sample type.
package frame_extremum_tracker_pkg;

    localparam int DATA_W = 4;

    typedef logic [DATA_W-1:0] sample_t;
    typedef logic [1:0]        cmp_code_t;

    // Codes understood by the downstream magnitude comparator stage.
    localparam cmp_code_t CMP_EQ  = 2'b00;
    localparam cmp_code_t CMP_AGT = 2'b01;
    localparam cmp_code_t CMP_BGT = 2'b10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    function automatic cmp_code_t cmp_encode(input sample_t a, input sample_t b);
        if (a > b)      return CMP_AGT;
        else if (b > a) return CMP_BGT;
        else            return CMP_EQ;
    endfunction

endpackage

// File: rtl/frame_extremum_tracker_if.sv
// Sample-in and record-out handshakes of the frame extremum tracker.
// The slave modport is the tracker's view, the master modport the environment's.
interface frame_extremum_tracker_if #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 4
);
    import frame_extremum_tracker_pkg::*;

    logic             in_valid;
    sample_t          in_data;
    logic             in_last;
    logic             in_ready;

    logic             out_valid;
    logic             out_ready;
    sample_t          out_max;
    sample_t          out_min;
    logic [IDX_W-1:0] out_max_idx;
    logic [CNT_W-1:0] out_rise_cnt;
    logic [IDX_W-1:0] out_len;
    logic             out_overflow;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_max, out_min, out_max_idx,
               out_rise_cnt, out_len, out_overflow
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_max, out_min, out_max_idx,
               out_rise_cnt, out_len, out_overflow
    );

endinterface

// File: rtl/frame_extremum_tracker_mag_cmp4.sv
// Combinational 4-bit unsigned magnitude comparator producing a shared result code.
module mag_cmp4
    import frame_extremum_tracker_pkg::*;
(
    input  sample_t   a,
    input  sample_t   b,
    output cmp_code_t code
);

    always_comb begin
        code = cmp_encode(a, b);
    end

endmodule

// File: rtl/frame_extremum_tracker.sv
// Streams a frame of 4-bit samples, tracks max/min/argmax/rise count and
// presents one registered result record per frame.
module frame_extremum_tracker
    import frame_extremum_tracker_pkg::*;
#(
    parameter int MAX_LEN = 15,
    parameter int IDX_W   = 4,
    parameter int CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    frame_extremum_tracker_if.slave  bus
);

    localparam logic [IDX_W-1:0] MAX_LEN_C = IDX_W'(MAX_LEN);

    logic [1:0]       state_q, state_d;
    sample_t          max_q, max_d;
    sample_t          min_q, min_d;
    sample_t          prev_q, prev_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] rise_q, rise_d;

    logic             ovld_q, ovld_d;
    sample_t          omax_q, omax_d;
    sample_t          omin_q, omin_d;
    logic [IDX_W-1:0] oidx_q, oidx_d;
    logic [CNT_W-1:0] orise_q, orise_d;
    logic [IDX_W-1:0] olen_q, olen_d;
    logic             oovf_q, oovf_d;

    cmp_code_t        cmp_max, cmp_min, cmp_prev;
    logic             xfer;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    mag_cmp4 u_cmp_max  (.a(bus.in_data), .b(max_q),  .code(cmp_max));
    mag_cmp4 u_cmp_min  (.a(bus.in_data), .b(min_q),  .code(cmp_min));
    mag_cmp4 u_cmp_prev (.a(bus.in_data), .b(prev_q), .code(cmp_prev));

    // in_ready depends on the state register alone, never on out_ready.
    assign bus.in_ready = (state_q != S_HOLD);
    assign xfer         = bus.in_valid && (state_q != S_HOLD);

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        min_d   = min_q;
        prev_d  = prev_q;
        idx_d   = idx_q;
        len_d   = len_q;
        rise_d  = rise_q;
        ovld_d  = ovld_q;
        omax_d  = omax_q;
        omin_d  = omin_q;
        oidx_d  = oidx_q;
        orise_d = orise_q;
        olen_d  = olen_q;
        oovf_d  = oovf_q;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    max_d   = bus.in_data;
                    min_d   = bus.in_data;
                    prev_d  = bus.in_data;
                    idx_d   = '0;
                    rise_d  = '0;
                    len_d   = IDX_W'(1);
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (xfer) begin
                    // Equal samples leave max alone so the earliest max index survives.
                    if (cmp_max == CMP_AGT) begin
                        max_d = bus.in_data;
                        idx_d = len_q;
                    end
                    if (cmp_min == CMP_BGT) begin
                        min_d = bus.in_data;
                    end
                    if (cmp_prev == CMP_AGT) begin
                        rise_d = sat_inc(rise_q);
                    end
                    prev_d = bus.in_data;
                    len_d  = len_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    ovld_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (xfer && (bus.in_last || len_d == MAX_LEN_C)) begin
            state_d = S_HOLD;
            ovld_d  = 1'b1;
            omax_d  = max_d;
            omin_d  = min_d;
            oidx_d  = idx_d;
            orise_d = rise_d;
            olen_d  = len_d;
            oovf_d  = !bus.in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            max_q   <= '0;
            min_q   <= '0;
            prev_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            rise_q  <= '0;
            ovld_q  <= 1'b0;
            omax_q  <= '0;
            omin_q  <= '0;
            oidx_q  <= '0;
            orise_q <= '0;
            olen_q  <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            min_q   <= min_d;
            prev_q  <= prev_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            rise_q  <= rise_d;
            ovld_q  <= ovld_d;
            omax_q  <= omax_d;
            omin_q  <= omin_d;
            oidx_q  <= oidx_d;
            orise_q <= orise_d;
            olen_q  <= olen_d;
            oovf_q  <= oovf_d;
        end
    end

    assign bus.out_valid    = ovld_q;
    assign bus.out_max      = omax_q;
    assign bus.out_min      = omin_q;
    assign bus.out_max_idx  = oidx_q;
    assign bus.out_rise_cnt = orise_q;
    assign bus.out_len      = olen_q;
    assign bus.out_overflow = oovf_q;

endmodule

// File: tb/tb_frame_extremum_tracker.sv
// Scoreboard bench for frame_extremum_tracker: directed frames plus a random stream,
// each closed frame modelled from its list of accepted samples.
module tb_frame_extremum_tracker;
    import frame_extremum_tracker_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    frame_extremum_tracker_if #(.IDX_W(4), .CNT_W(4)) bus ();

    frame_extremum_tracker #(.MAX_LEN(15), .IDX_W(4), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mx; int mn; int idx; int rise; int len; int ovf; int cyc;
    } rec_t;

    rec_t exp_q[$];
    int   cur[$];
    rec_t last_rec;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ordy_mode = 0;
    bit   mon_en = 0;
    bit   prev_vld = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Frame result computed directly from the list of accepted samples.
    function automatic rec_t model(input int s[$], input bit last, input int c);
        rec_t r;
        r.mx = s[0]; r.mn = s[0]; r.idx = 0; r.rise = 0;
        foreach (s[i]) begin
            if (s[i] > r.mx) begin r.mx = s[i]; r.idx = i; end
            if (s[i] < r.mn) r.mn = s[i];
            if (i > 0 && s[i] > s[i-1]) r.rise++;
        end
        if (r.rise > 15) r.rise = 15;
        r.len = s.size();
        r.ovf = (!last && s.size() == 15) ? 1 : 0;
        r.cyc = c;
        return r;
    endfunction

    task automatic note_accept(input int d, input bit last);
        cur.push_back(d);
        if (last || cur.size() == 15) begin
            exp_q.push_back(model(cur, last, cyc));
            cur.delete();
        end
    endtask

    task automatic send(input int d, input bit last);
        int  n;
        bit  rdy;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'(d);
        bus.in_last  = last;
        forever begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                note_accept(d, last);
                break;
            end
            n++;
            if (n > 60) begin
                total++; bad++;
                $display("FAIL send_timeout: sample %0d not accepted after %0d cycles", d, n);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_max"}, int'(bus.out_max), 0);
        chk({tag, "_min"}, int'(bus.out_min), 0);
        chk({tag, "_idx"}, int'(bus.out_max_idx), 0);
        chk({tag, "_rise"}, int'(bus.out_rise_cnt), 0);
        chk({tag, "_len"}, int'(bus.out_len), 0);
        chk({tag, "_ovf"}, int'(bus.out_overflow), 0);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cur.delete();
        last_rec = '{default: 0};
        check_zero("reset_mid");
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ordy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom % 2);
            endcase
        end
    end

    // Monitor: compares presented records against the head of the expected queue.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("in_ready_hold", int'(bus.in_ready), int'(!bus.out_valid));
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_record: max=%0d len=%0d with nothing expected",
                                 bus.out_max, bus.out_len);
                    end else begin
                        r = exp_q[0];
                        if (!prev_vld) chk("latency_cycle", cyc, r.cyc);
                        chk("rec_max", int'(bus.out_max), r.mx);
                        chk("rec_min", int'(bus.out_min), r.mn);
                        chk("rec_idx", int'(bus.out_max_idx), r.idx);
                        chk("rec_rise", int'(bus.out_rise_cnt), r.rise);
                        chk("rec_len", int'(bus.out_len), r.len);
                        chk("rec_ovf", int'(bus.out_overflow), r.ovf);
                        if (bus.out_ready) begin
                            last_rec = r;
                            void'(exp_q.pop_front());
                        end
                    end
                end else begin
                    chk("kept_max", int'(bus.out_max), last_rec.mx);
                    chk("kept_min", int'(bus.out_min), last_rec.mn);
                    chk("kept_len", int'(bus.out_len), last_rec.len);
                    chk("kept_ovf", int'(bus.out_overflow), last_rec.ovf);
                end
                prev_vld = bus.out_valid;
            end
        end
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        last_rec = '{default: 0};
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero("reset_init");
        mon_en = 1'b1;
        ordy_mode = 1;
        idle(1);

        send(3, 0); send(9, 0); send(9, 0); send(2, 0); send(7, 1);
        idle(3);

        send(15, 1);
        idle(3);

        ordy_mode = 0;
        idle(1);
        send(1, 0); send(2, 1);
        fork
            begin
                repeat (6) @(posedge clk);
                ordy_mode = 1;
            end
        join_none
        send(8, 1);
        idle(3);

        for (int i = 0; i < 15; i++) send(i, 0);
        send(5, 1);
        idle(3);

        send(1, 0); send(2, 0); send(3, 0);
        do_reset();
        send(6, 0); send(6, 1);
        idle(3);

        send(4, 0); idle(2); send(1, 0); idle(1); send(8, 1);
        idle(3);

        ordy_mode = 2;
        repeat (300) begin
            if ($urandom % 4 == 0) idle(int'($urandom_range(1, 3)));
            send(int'($urandom % 16), 1'($urandom % 7 == 0));
        end
        send(int'($urandom % 16), 1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d records still expected", exp_q.size());
        end
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_extremum_tracker.md
Name: frame_extremum_tracker

Overview:
- Streaming stage that feeds the 4-bit magnitude comparator.
- Accepts a frame of unsigned 4-bit samples over a valid/ready handshake.
- Tracks running max, min, argmax index and the count of rising steps, using comparator instances. Presents one registered result record per frame over a second valid/ready handshake.
- Sits between the sample source and downstream control/display logic.

Parameters:
- MAX_LEN, 15, maximum samples per frame; frame is force-closed when reached.
- IDX_W, 4, width of index/length fields; must satisfy 2^IDX_W > MAX_LEN.
- CNT_W, 4, width of rise counter; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data/in_last valid this cycle.
- in_data  in  4  unsigned sample.
- in_last  in  1  sample is last of frame.
- in_ready  out  1  block can accept a sample.
- out_valid  out  1  result record valid.
- out_ready  in  1  consumer takes record.
- out_max  out  4  frame maximum.
- out_min  out  4  frame minimum.
- out_max_idx  out  IDX_W  0-based index of first occurrence of max.
- out_rise_cnt  out  CNT_W  number of samples strictly greater than the previous sample.
- out_len  out  IDX_W  samples in frame.
- out_overflow  out  1  frame closed by MAX_LEN, not by in_last.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous, active-high. On a clk edge with reset=1:
  - state -> S_IDLE.
  - out_valid, out_max, out_min, out_max_idx, out_rise_cnt, out_len, out_overflow all -> 0.
  - internal accumulators -> 0.
  - Samples presented while reset=1 are discarded.
  - Reset mid-frame or mid-hold discards everything; no partial record is emitted.
- States:
  - S_IDLE: no frame open.
  - S_ACC: frame open.
  - S_HOLD: record presented.
- in_ready = 1 in S_IDLE and S_ACC, 0 in S_HOLD. It is decoded from the state register only, with no combinational path from out_ready.
- Transfer occurs when in_valid && in_ready. Cycles with in_valid=0 change nothing.
- First sample of a frame (S_IDLE): max=min=prev=data, idx=0, rise=0, len=1.
- Subsequent sample (S_ACC), using comparator codes:
  - data > max: max=data, idx=len. Equal does not update, so the earliest max wins.
  - data < min: min=data.
  - data > prev: rise++ (saturating).
  - prev=data, len++.
- Frame close happens when the accepted sample has in_last=1, or when the new len equals MAX_LEN:
  - Next cycle: state S_HOLD, out_valid=1, out_* loaded with final values.
  - out_overflow=1 only if close was by MAX_LEN with in_last=0.
  - in_last on the MAX_LEN-th sample gives out_overflow=0.
- Latency: out_valid asserts exactly 1 cycle after the closing transfer.
- A single-sample frame goes S_IDLE -> S_HOLD directly.
- S_HOLD:
  - out_* held stable while out_ready=0.
  - On out_valid && out_ready: next cycle out_valid=0, state S_IDLE, in_ready=1.
  - out_* keep their last values after out_valid drops.
  - With out_ready held high, out_valid is a 1-cycle pulse. The minimum frame-to-frame gap is 1 idle cycle.
- No combinational path from any input to any output.

Decomposition:
- Shared package/header holds:
  - Comparator result codes: CMP_EQ=2'b00, CMP_AGT=2'b01, CMP_BGT=2'b10. All stages decode these names, never literals.
  - State encodings S_IDLE=0, S_ACC=1, S_HOLD=2.
- One sub-module, mag_cmp4: combinational 4-bit unsigned compare with inputs a, b and a 2-bit code output.
  - Instantiated three times: data vs max, data vs min, data vs prev.
  - This is the interface the downstream comparator stage already speaks.

Test Plan:
- Frame 3,9,9,2,7 (last on 7), out_ready=1 -> one cycle after the 7 transfer: out_valid=1, max=9, max_idx=1, min=2, rise_cnt=2, len=5, overflow=0; next cycle out_valid=0, in_ready=1.
- Single sample 4'hF with in_last -> next cycle out_valid=1, max=min=15, max_idx=0, rise_cnt=0, len=1.
- Frame 1,2 last with out_ready=0 for 5 cycles, in_valid=1 data=8 throughout:
  - in_ready=0 and record stable for all 5 cycles; 8 is not accepted.
  - After out_ready=1: S_IDLE, and 8 starts a new frame.
- 15 samples 0..14, no in_last -> forced close: max=14, max_idx=14, min=0, rise_cnt=14, len=15, overflow=1. A following sample 5 with last yields len=1, max=5, overflow=0.
- reset=1 for 1 cycle after 3 samples of a frame -> all outputs 0, no out_valid. Then 6,6 last -> max=6, max_idx=0, min=6, rise_cnt=0, len=2.
- Frame 4,_,_,1,_,8 (in_valid low on gaps, last on 8) -> identical to back-to-back 4,1,8: max=8, max_idx=2, min=1, rise_cnt=1, len=3.
